// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract core: operation codes and result flags.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SBC  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  // Subtract forms add the one's complement of B.
  function automatic logic invert_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // OP_SUB forces the +1 of two's complement; ADD/SBC/reserved take the caller's carry.
  function automatic logic eff_carry(input op_e op, input logic c_in);
    return (op == OP_SUB) ? 1'b1 : c_in;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready stream bundle between an issuing client and the pipelined adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  import adder_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_c_in;
  op_e              i_op;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_c_out;
  logic             o_ovf;
  logic             o_zero;
  logic             o_neg;

  modport master (
    output i_valid, i_a, i_b, i_c_in, i_op, i_ready,
    input  o_ready, o_valid, o_sum, o_c_out, o_ovf, o_zero, o_neg
  );

  modport slave (
    input  i_valid, i_a, i_b, i_c_in, i_op, i_ready,
    output o_ready, o_valid, o_sum, o_c_out, o_ovf, o_zero, o_neg
  );

endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK_W-bit ripple adder; also reports the carry into its MSB for overflow.
module adder_chunk #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               c_in,
  output logic [CHUNK_W-1:0] sum,
  output logic               c_out,
  output logic               c_msb
);

  logic [CHUNK_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, c_in};
  assign sum   = total[CHUNK_W-1:0];
  assign c_out = total[CHUNK_W];
  // Recover the carry entering the top bit from that bit's sum and operands.
  assign c_msb = total[CHUNK_W-1] ^ a[CHUNK_W-1] ^ b[CHUNK_W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES chunks, one resolved per
// registered stage, behind a valid/ready stream with collapsing bubbles.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  pipelined_adder_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
  end

  // Per-stage registered state; index k is stage k.
  logic [STAGES-1:0]            vld_p;
  logic [STAGES-1:0][WIDTH-1:0] a_p;
  logic [STAGES-1:0][WIDTH-1:0] b_p;
  logic [STAGES-1:0][WIDTH-1:0] sum_p;
  logic [STAGES-1:0]            c_p;
  logic [STAGES-1:0]            z_p;
  logic                         cm_p;

  // What each stage sees at its input this cycle.
  logic [STAGES-1:0][WIDTH-1:0] a_s;
  logic [STAGES-1:0][WIDTH-1:0] b_s;
  logic [STAGES-1:0][WIDTH-1:0] sum_s;
  logic [STAGES-1:0]            c_s;
  logic [STAGES-1:0]            z_s;
  logic [STAGES-1:0]            vin_s;

  logic [STAGES-1:0][CHUNK-1:0] s_w;
  logic [STAGES-1:0]            co_w;
  logic [STAGES-1:0]            cm_w;
  logic [STAGES-1:0][WIDTH-1:0] sum_nx;
  logic [STAGES-1:0]            z_nx;

  logic [STAGES-1:0] ld;
  logic              accept;
  logic [WIDTH-1:0]  b_eff;
  flags_t            flg;
  logic              unused_fwd;

  function automatic flags_t result_flags(input logic vld, input logic co, input logic cm,
                                          input logic z, input logic msb);
    flags_t f;
    f.c_out = vld & co;
    f.ovf   = vld & (co ^ cm);
    f.zero  = vld & z;
    f.neg   = vld & msb;
    return f;
  endfunction

  // A stage loads when empty or when its content moves on; walking back from the
  // consumer lets a full pipe accept and drain in the same cycle.
  always_comb begin : ready_chain
    logic go;
    go = bus.i_ready;
    ld = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !vld_p[k] || go;
      go    = ld[k];
    end
  end

  assign bus.o_ready = i_rst_n && ld[0];
  assign accept      = bus.i_valid && bus.o_ready;
  assign b_eff       = invert_b(bus.i_op) ? ~bus.i_b : bus.i_b;

  always_comb begin
    a_s   = '0;
    b_s   = '0;
    sum_s = '0;
    c_s   = '0;
    z_s   = '0;
    vin_s = '0;
    a_s[0]   = bus.i_a;
    b_s[0]   = b_eff;
    c_s[0]   = eff_carry(bus.i_op, bus.i_c_in);
    z_s[0]   = 1'b1;
    vin_s[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      a_s[k]   = a_p[k-1];
      b_s[k]   = b_p[k-1];
      sum_s[k] = sum_p[k-1];
      c_s[k]   = c_p[k-1];
      z_s[k]   = z_p[k-1];
      vin_s[k] = vld_p[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.CHUNK_W(CHUNK)) u_chunk (
      .a     (a_s[k][k*CHUNK +: CHUNK]),
      .b     (b_s[k][k*CHUNK +: CHUNK]),
      .c_in  (c_s[k]),
      .sum   (s_w[k]),
      .c_out (co_w[k]),
      .c_msb (cm_w[k])
    );
  end

  always_comb begin
    sum_nx = sum_s;
    z_nx   = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum_nx[k][k*CHUNK +: CHUNK] = s_w[k];
      z_nx[k] = z_s[k] && (s_w[k] == '0);
    end
  end

  // ---- stage boundary: valid bits (the only reset state) ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) vld_p[k] <= vin_s[k];
      end
    end
  end

  // ---- stage boundary: data registers, written only when a real operation enters ----
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (ld[k] && vin_s[k]) begin
        a_p[k]   <= a_s[k];
        b_p[k]   <= b_s[k];
        sum_p[k] <= sum_nx[k];
        c_p[k]   <= co_w[k];
        z_p[k]   <= z_nx[k];
      end
    end
    if (ld[STAGES-1] && vin_s[STAGES-1]) cm_p <= cm_w[STAGES-1];
  end

  // Consumed operand chunks and interior MSB carries are dead past their own stage.
  assign unused_fwd = ^{a_p, b_p, cm_w};

  assign flg = result_flags(vld_p[STAGES-1], c_p[STAGES-1], cm_p, z_p[STAGES-1],
                            sum_p[STAGES-1][WIDTH-1]);

  assign bus.o_valid = vld_p[STAGES-1];
  assign bus.o_sum   = vld_p[STAGES-1] ? sum_p[STAGES-1] : '0;
  assign bus.o_c_out = flg.c_out;
  assign bus.o_ovf   = flg.ovf;
  assign bus.o_zero  = flg.zero;
  assign bus.o_neg   = flg.neg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 32-bit/4-stage unit and an 8-bit/1-stage unit.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int S32 = 4;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] sum;
    logic [3:0]  f;   // {c_out, ovf, zero, neg}
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  f;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) v32 ();
  pipelined_adder_if #(.WIDTH(8))  v8 ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(v32.slave));
  pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(v8.slave));

  vec_t tab [16] = '{
    '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010},
    '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b1100},
    '{OP_SBC,  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 4'b0001},
    '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101},
    '{OP_ADD,  32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 4'b0000},
    '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1010},
    '{OP_SBC,  32'h0000_0005, 32'h0000_0005, 1'b0, 32'hFFFF_FFFF, 4'b0001},
    '{OP_RSVD, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 4'b0000},
    '{OP_ADD,  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110},
    '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b0001},
    '{OP_ADD,  32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000},
    '{OP_SUB,  32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0101},
    '{OP_ADD,  32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 4'b0000},
    '{OP_SBC,  32'h8000_0000, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 4'b1100},
    '{OP_ADD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 4'b1001},
    '{OP_SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 4'b0101}
  };

  vec_t tab8 [4] = '{
    '{OP_ADD, 32'h7F, 32'h01, 1'b0, 32'h80, 4'b0101},
    '{OP_ADD, 32'hFF, 32'h01, 1'b0, 32'h00, 4'b1010},
    '{OP_SUB, 32'h00, 32'h01, 1'b0, 32'hFF, 4'b0001},
    '{OP_SBC, 32'h80, 32'h01, 1'b1, 32'h7F, 4'b1100}
  };

  sb_t q32[$];
  sb_t q8[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // 32-bit result monitor plus hold-while-stalled check.
  bit          stall_prev = 1'b0;
  logic [36:0] held = '0;
  always @(negedge clk) begin : mon32
    sb_t e;
    if (v32.o_valid && v32.i_ready) begin
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res32_unexpected: got sum=%h with no operation outstanding", v32.o_sum);
      end else begin
        e = q32.pop_front();
        chk("res32", 64'({v32.o_sum, v32.o_c_out, v32.o_ovf, v32.o_zero, v32.o_neg}),
            64'({e.sum, e.f}));
        if (chk_lat) chk("lat32", 64'(cyc - e.cyc), 64'(S32));
      end
    end
    if (stall_prev)
      chk("stall_hold", 64'({v32.o_valid, v32.o_sum, v32.o_c_out, v32.o_ovf, v32.o_zero, v32.o_neg}),
          64'(held));
    stall_prev <= v32.o_valid && !v32.i_ready;
    held <= {v32.o_valid, v32.o_sum, v32.o_c_out, v32.o_ovf, v32.o_zero, v32.o_neg};
  end

  always @(negedge clk) begin : mon8
    sb_t e;
    if (v8.o_valid && v8.i_ready) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res8_unexpected: got sum=%h with no operation outstanding", v8.o_sum);
      end else begin
        e = q8.pop_front();
        chk("res8", 64'({v8.o_sum, v8.o_c_out, v8.o_ovf, v8.o_zero, v8.o_neg}),
            64'({e.sum[7:0], e.f}));
        chk("lat8", 64'(cyc - e.cyc), 64'd1);
      end
    end
  end

  task automatic drive32(input vec_t t);
    v32.i_a    = t.a;
    v32.i_b    = t.b;
    v32.i_c_in = t.c;
    v32.i_op   = t.op;
  endtask

  task automatic push32(input vec_t t);
    sb_t e;
    e.sum = t.sum;
    e.f   = t.f;
    e.cyc = cyc;
    q32.push_back(e);
  endtask

  task automatic issue32(input vec_t t, output int tries);
    bit acc;
    acc = 1'b0;
    tries = 0;
    drive32(t);
    v32.i_valid = 1'b1;
    while (!acc && tries < 100) begin
      @(negedge clk);
      tries++;
      if (v32.o_ready) begin
        push32(t);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    v32.i_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL issue32_timeout: got no o_ready in %0d cycles, expected acceptance", tries);
    end
  endtask

  task automatic issue8(input vec_t t);
    sb_t e;
    bit  acc;
    acc = 1'b0;
    v8.i_a     = t.a[7:0];
    v8.i_b     = t.b[7:0];
    v8.i_c_in  = t.c;
    v8.i_op    = t.op;
    v8.i_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (v8.o_ready) begin
        e.sum = t.sum;
        e.f   = t.f;
        e.cyc = cyc;
        q8.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    v8.i_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL issue8_timeout: got no o_ready, expected acceptance");
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && (q32.size() != 0 || q8.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk(nm, 64'(q32.size() + q8.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tries;
    int n;
    int idx;
    v32.i_valid = 1'b0; v32.i_ready = 1'b1; v32.i_a = '0; v32.i_b = '0;
    v32.i_c_in = 1'b0;  v32.i_op = OP_ADD;
    v8.i_valid  = 1'b0; v8.i_ready  = 1'b1; v8.i_a  = '0; v8.i_b  = '0;
    v8.i_c_in  = 1'b0;  v8.i_op  = OP_ADD;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst32_state", 64'({v32.o_ready, v32.o_valid, v32.o_sum, v32.o_c_out, v32.o_ovf,
                            v32.o_zero, v32.o_neg}), 64'd0);
    chk("rst8_state", 64'({v8.o_ready, v8.o_valid, v8.o_sum, v8.o_c_out, v8.o_ovf,
                           v8.o_zero, v8.o_neg}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy32_after_rst", 64'(v32.o_ready), 64'd1);
    chk("rdy8_after_rst", 64'(v8.o_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single op, then 16 back-to-back with i_ready high
    chk_lat = 1'b1;
    issue32(tab[0], tries);
    drain("drain_single");
    for (int i = 0; i < 16; i++) begin
      issue32(tab[i], tries);
      chk("b2b_accept", 64'(tries), 64'd1);
    end
    drain("drain_b2b");

    // Single-stage 8-bit unit
    for (int i = 0; i < 4; i++) issue8(tab8[i]);
    drain("drain8");

    // Downstream stall: pipe fills to capacity, then o_ready drops
    chk_lat = 1'b0;
    v32.i_ready = 1'b0;
    n = 0;
    idx = 2;
    for (int c = 0; c < 6; c++) begin
      drive32(tab[idx]);
      v32.i_valid = 1'b1;
      @(negedge clk);
      if (v32.o_ready) begin
        push32(tab[idx]);
        n++;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    v32.i_valid = 1'b0;
    @(negedge clk);
    chk("stall_accepts", 64'(n), 64'd4);
    chk("stall_ready_low", 64'(v32.o_ready), 64'd0);
    chk("stall_valid_high", 64'(v32.o_valid), 64'd1);
    @(posedge clk);
    #1;
    // Release while issuing: full pipe accepts and drains together
    v32.i_ready = 1'b1;
    issue32(tab[idx], tries);
    chk("full_accept_drain", 64'(tries), 64'd1);
    @(negedge clk);
    chk("full_occupancy", 64'(v32.o_valid), 64'd1);
    @(posedge clk);
    #1;
    drain("drain_stall");

    // Reset with three operations in flight
    chk_lat = 1'b1;
    for (int i = 3; i < 6; i++) issue32(tab[i], tries);
    rst_n = 1'b0;
    q32.delete();
    @(negedge clk);
    chk("rst_ready_low", 64'(v32.o_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_flush_state", 64'({v32.o_valid, v32.o_sum, v32.o_c_out, v32.o_ovf, v32.o_zero,
                               v32.o_neg}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("no_stale_valid", 64'(v32.o_valid), 64'd0);
    @(posedge clk);
    #1;
    issue32(tab[13], tries);
    chk("post_rst_accept", 64'(tries), 64'd1);
    drain("drain_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
